bpu_sram_1r1w_init: RTL
=======================

Name: bpu_sram_1r1w_init

Overview:
- Parametrised 1-read/1-write SRAM array for BPU predictor tables (uBTB, FTB, TAGE).
- Successor to the single-port fixed-width macro, with:
  - WAYS independent ways and a per-way write mask;
  - a self-clearing initialisation sweep after reset or on request;
  - a held read output, with valid/ready handshakes on both ports.
- Sits between predictor table logic and the raw storage array.

Parameters:
- DEPTH, 128, number of entries; power of two, ≥ 2.
- ADDR_W, 7, address width; equals log2(DEPTH).
- WAYS, 2, number of ways per entry.
- DATA_W, 53, bits per way.
- INIT_VAL, 0, value written to every way of every entry during the init sweep.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- init_req  in  1  one-cycle pulse that restarts the clear sweep; ignored while already initialising.
- init_done  out  1  high when the array is usable.
- r_valid  in  1  read request.
- r_ready  out  1  read accepted when r_valid && r_ready.
- r_addr  in  ADDR_W  read address.
- r_resp_valid  out  1  read data valid; pulses one cycle after acceptance.
- r_data  out  WAYS*DATA_W  read data; way i occupies bits [i*DATA_W +: DATA_W].
- w_valid  in  1  write request.
- w_ready  out  1  write accepted when w_valid && w_ready.
- w_addr  in  ADDR_W  write address.
- w_mask  in  WAYS  per-way write enable.
- w_data  in  WAYS*DATA_W  write data.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - Reset state: state=INIT, init_ptr=0, init_done=0, r_ready=0, w_ready=0, r_resp_valid=0, r_data=0.
  - Array contents are not reset directly; the INIT sweep clears them.
- State machine: INIT and IDLE.
  - INIT: write INIT_VAL to all ways at init_ptr, then increment init_ptr. At init_ptr==DEPTH-1 the cycle writes, then moves to IDLE.
  - INIT lasts exactly DEPTH cycles after reset release; init_done rises on the following cycle.
  - IDLE: init_done=1, r_ready=1, w_ready=1.
  - init_req in IDLE → INIT with init_ptr=0. In that same cycle r_ready/w_ready are already low; init_done drops next cycle.
  - reset_n asserted at any point → immediately back to the reset state; the sweep restarts from 0 on release.
- During INIT:
  - r_ready=0 and w_ready=0; external requests are not accepted and have no effect.
  - r_resp_valid stays 0.
  - r_data holds its last value; it is 0 after reset.
- Read:
  - Latency 1: the array is read at the accept edge, r_resp_valid=1 the next cycle, then 0 unless another read is accepted.
  - r_data holds the last response until the next accepted read.
  - Back-to-back reads are accepted at one per cycle.
- Write:
  - Accepted write updates only ways with w_mask[i]=1; other ways keep their contents.
  - w_mask=0 is accepted and has no effect.
- Simultaneous read and write, different addresses: both are performed.
- Simultaneous read and write, same address: read returns pre-write (old) data for every way, unless the optional feature below is enabled.
- Pointer width: init_ptr is ADDR_W bits. End of sweep is detected by compare with DEPTH-1, never by wrap.

Optional Feature:
- Macro: BPU_SRAM_WRITE_BYPASS_EN.
- Defined: on a same-cycle, same-address read and write, each way with w_mask[i]=1 returns w_data for that way; unmasked ways return old data. Forwarding is registered with the read, so latency stays 1.
- Undefined: no forwarding; old data is returned as above and no bypass logic is synthesised.

Decomposition:
- Shared package bpu_sram_pkg holds:
  - state enum typedef (INIT, IDLE);
  - localparam helper for ADDR_W from DEPTH;
  - way-slice index function.
- One natural sub-module: bpu_sram_array_core.
  - Raw DEPTH×(WAYS*DATA_W) storage with per-way write enable and a synchronous read port.
  - No reset, no control logic; later swappable for a foundry macro.
- The top level holds the FSM, init_ptr, handshakes, output hold register and bypass mux.

Test Plan:
- Release reset_n with DEPTH=128 → init_done=0 for cycles 0..127, init_done=1 at cycle 128; then reading addresses 0, 64, 127 returns all-zero data.
- Write addr 5, w_mask=2'b10, way1=0x1ABCD, way0=0x3; then read addr 5 → r_resp_valid one cycle after accept; r_data way1=0x1ABCD, way0=0; r_data holds with r_valid low.
- Same-cycle read and write of addr 9 (old data 0x11 in both ways, new data 0x22, w_mask=2'b11):
  - macro undefined → both ways read 0x11; next read returns 0x22;
  - macro defined → both ways read 0x22 immediately.
- Pulse init_req after filling addresses 0..3 → r_ready and w_ready fall the same cycle, init_done low for 128 cycles, then addresses 0..3 read 0.
- Assert reset_n low at init_ptr=60, hold 2 cycles, release → sweep restarts at 0 and init_done rises 128 cycles after release; r_data=0 during reset.
- Drive r_valid and w_valid during INIT → no accept, no r_resp_valid pulse, array unchanged (verified by later reads returning 0).

Source files
------------

// File: rtl/bpu_sram_pkg.sv
// Shared definitions for the BPU 1R1W predictor-table SRAM.
//   sram_state_e : controller state (INIT sweep / IDLE service)
//   addr_w_of()  : address width for a given power-of-two depth
//   way_lsb()    : low bit of a way slice inside a packed WAYS*DATA_W word
package bpu_sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } sram_state_e;

  function automatic int addr_w_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int way_lsb(input int way, input int data_w);
    return way * data_w;
  endfunction

endpackage

// File: rtl/bpu_sram_array_core.sv
// Raw DEPTH x (WAYS*DATA_W) storage, one independent bank per way.
// No reset and no control logic, so it can be replaced by a foundry macro.
// Ports:
//   clock      : rising-edge clock
//   rd_en_i    : read enable; rd_data_o updates on the next edge, else holds
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (old data on same-address write)
//   wr_en_i    : per-way write enable
//   wr_addr_i  : write address
//   wr_data_i  : write data, way i at [i*DATA_W +: DATA_W]
module bpu_sram_array_core
  import bpu_sram_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7,
  parameter int WAYS   = 2,
  parameter int DATA_W = 53
) (
  input  logic                     clock,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  output logic [WAYS*DATA_W-1:0]   rd_data_o,
  input  logic [WAYS-1:0]          wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [WAYS*DATA_W-1:0]   wr_data_i
);

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [DATA_W-1:0] mem_q [DEPTH];
      logic [DATA_W-1:0] rd_q;

      // Read and write share one process: the read samples the pre-write
      // contents, which gives read-old-data on a same-address collision.
      always_ff @(posedge clock) begin
        if (wr_en_i[gi]) begin
          mem_q[wr_addr_i] <= wr_data_i[way_lsb(gi, DATA_W) +: DATA_W];
        end
        if (rd_en_i) begin
          rd_q <= mem_q[rd_addr_i];
        end
      end

      assign rd_data_o[way_lsb(gi, DATA_W) +: DATA_W] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/bpu_sram_1r1w_init.sv
// BPU predictor-table SRAM: 1 read + 1 write port, WAYS ways with per-way
// write mask, self-clearing init sweep after reset or on init_req, and a
// held read-response register.
// Optional macro BPU_SRAM_WRITE_BYPASS_EN: a same-cycle same-address write
// forwards its masked ways into the read response (latency unchanged).
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   init_req / init_done  : restart clear sweep / array usable
//   r_valid, r_ready, r_addr            : read request handshake
//   r_resp_valid, r_data                : read response (held between reads)
//   w_valid, w_ready, w_addr, w_mask, w_data : write request handshake
module bpu_sram_1r1w_init
  import bpu_sram_pkg::*;
#(
  parameter int                DEPTH    = 128,
  parameter int                ADDR_W   = addr_w_of(DEPTH),
  parameter int                WAYS     = 2,
  parameter int                DATA_W   = 53,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   init_req,
  output logic                   init_done,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [ADDR_W-1:0]      r_addr,
  output logic                   r_resp_valid,
  output logic [WAYS*DATA_W-1:0] r_data,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [ADDR_W-1:0]      w_addr,
  input  logic [WAYS-1:0]        w_mask,
  input  logic [WAYS*DATA_W-1:0] w_data
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  sram_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       init_ptr_q, init_ptr_d;
  logic                    r_resp_valid_q;
  logic [WAYS*DATA_W-1:0]  r_hold_q;

  logic                    idle;
  logic                    r_acc;
  logic                    w_acc;
  logic [WAYS-1:0]         core_wr_en;
  logic [ADDR_W-1:0]       core_wr_addr;
  logic [WAYS*DATA_W-1:0]  core_wr_data;
  logic [WAYS*DATA_W-1:0]  core_rd_data;
  logic [WAYS*DATA_W-1:0]  resp_data;

  assign idle      = (state_q == ST_IDLE);
  assign init_done = idle;
  // Ready drops combinationally on init_req so nothing is accepted in the
  // cycle that starts a new sweep.
  assign r_ready   = idle && !init_req;
  assign w_ready   = idle && !init_req;
  assign r_acc     = r_valid && r_ready;
  assign w_acc     = w_valid && w_ready;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      ST_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_PTR) begin
          state_d    = ST_IDLE;
          init_ptr_d = '0;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d    = ST_INIT;
          init_ptr_d = '0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Sweep owns the write port while initialising; all ways written at once.
  assign core_wr_en   = idle ? ({WAYS{w_acc}} & w_mask) : {WAYS{1'b1}};
  assign core_wr_addr = idle ? w_addr : init_ptr_q;
  assign core_wr_data = idle ? w_data : {WAYS{INIT_VAL}};

  bpu_sram_array_core #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WAYS   (WAYS),
    .DATA_W (DATA_W)
  ) u_core (
    .clock     (clock),
    .rd_en_i   (r_acc),
    .rd_addr_i (r_addr),
    .rd_data_o (core_rd_data),
    .wr_en_i   (core_wr_en),
    .wr_addr_i (core_wr_addr),
    .wr_data_i (core_wr_data)
  );

`ifdef BPU_SRAM_WRITE_BYPASS_EN
  // Collision info is captured alongside the read so the forward is
  // applied in the response cycle.
  logic [WAYS-1:0]        byp_mask_q;
  logic [WAYS*DATA_W-1:0] byp_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else if (r_acc) begin
      byp_mask_q <= (w_acc && (w_addr == r_addr)) ? w_mask : '0;
      byp_data_q <= w_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_byp
      assign resp_data[way_lsb(gi, DATA_W) +: DATA_W] = byp_mask_q[gi]
          ? byp_data_q[way_lsb(gi, DATA_W) +: DATA_W]
          : core_rd_data[way_lsb(gi, DATA_W) +: DATA_W];
    end
  endgenerate
`else
  assign resp_data = core_rd_data;
`endif

  // The core output is unreset, so a separate hold register provides the
  // zero-after-reset value and keeps the last response between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_resp_valid_q <= 1'b0;
      r_hold_q       <= '0;
    end else begin
      r_resp_valid_q <= r_acc;
      if (r_resp_valid_q) begin
        r_hold_q <= resp_data;
      end
    end
  end

  assign r_resp_valid = r_resp_valid_q;
  assign r_data       = r_resp_valid_q ? resp_data : r_hold_q;

endmodule
